frame_transmission: RTL and testbench
=====================================

# frame_transmission

Transmit-side Ethernet framer for the MAC controller. On a single start pulse it latches the header fields and payload, then emits a complete frame one byte per clock on the byte stream towards the MAC/PHY. The frame is preamble, SFD, destination MAC, source MAC, EtherType, payload and a CRC-32 FCS computed on the fly. It is the counterpart of the frame receiver and uses the same byte encodings and field orders.

## Interface
- `PAYLOAD_BYTES`, default 4: payload length in bytes, at least 1.
- `IFG_CYCLES`, default 12: idle cycles enforced after each frame, at least 1.
- `clk`, input, 1: single clock; all logic uses the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `tx_start`, input, 1: request to send; accepted only while `tx_ready`=1.
- `dest_mac`, input, 48: destination MAC, sampled at accept.
- `src_mac`, input, 48: source MAC, sampled at accept.
- `eth_type`, input, 16: EtherType, sampled at accept.
- `payload`, input, 8*PAYLOAD_BYTES: payload, sampled at accept.
- `tx_ready`, output, 1: high when idle and able to accept.
- `tx_data`, output, 8: outgoing byte.
- `tx_data_valid`, output, 1: `tx_data` carries a frame byte this cycle.
- `tx_done`, output, 1: one-cycle pulse after the last FCS byte.

## Operation
- **Reset values:** `tx_ready`=1, `tx_data`=8'h00, `tx_data_valid`=0, `tx_done`=0. State is IDLE, all counters are 0, the CRC register is 32'hFFFFFFFF and the latched fields are 0.
- **Accept:** `tx_start`=1 while `tx_ready`=1 at a rising edge latches all four field inputs and moves the FSM to PREAMBLE. `tx_start` while `tx_ready`=0 is ignored and is not queued.
- **States and transitions:**
  - IDLE → PREAMBLE on accept.
  - PREAMBLE: 7 bytes of 8'hAA, then SFD.
  - SFD: 1 byte of 8'hAB, then DEST.
  - DEST: 6 bytes, then SRC.
  - SRC: 6 bytes, then TYPE.
  - TYPE: 2 bytes, then PAYLOAD.
  - PAYLOAD: PAYLOAD_BYTES bytes, then FCS.
  - FCS: 4 bytes, then IFG.
  - IFG: IFG_CYCLES cycles, then IDLE.
  - Unreachable encodings return to IDLE with outputs at their reset values.
- **Byte order:** all fields go MSB byte first. For example, `dest_mac[47:40]` is sent first and `payload[8*PAYLOAD_BYTES-1 -: 8]` is the first payload byte.
- **Byte counter:** one shared counter, cleared on every state change, compared against the state's length minus one. It must be wide enough for max(7, PAYLOAD_BYTES, IFG_CYCLES).
- **CRC-32:**
  - Reflected polynomial 32'hEDB88320, initial value 32'hFFFFFFFF, processed byte-wise LSB-bit first.
  - Covers exactly the DEST, SRC, TYPE and PAYLOAD bytes; preamble and SFD are excluded.
  - The register is updated with each covered byte in the same cycle that byte is driven.
  - FCS = ~crc_reg, sent as FCS[31:24], [23:16], [15:8], [7:0].
  - The register is re-initialised on accept.
- **Outputs during IFG:** `tx_data_valid`=0 and `tx_data`=8'h00.
- **`tx_done`:** high exactly in the first IFG cycle.
- **Reset mid-frame:** asserting `rst_n` low forces all outputs to their reset values immediately. No remaining bytes are emitted, and `tx_done` does not fire for the aborted frame.

## Timing
- Frame length is N = 26 + PAYLOAD_BYTES bytes (30 at default).
- Let T be the rising edge at which a start is accepted.
- `tx_ready` falls after edge T.
- The first preamble byte is valid in cycle T+1. The bytes are contiguous: `tx_data_valid`=1 for cycles T+1 … T+N with no gaps.
- `tx_done`=1 in cycle T+N+1 only.
- `tx_ready` returns to 1 in cycle T+N+1+IFG_CYCLES. The earliest next accept is at that edge.
- Start-to-first-byte latency is 1 cycle. Back-to-back frames are spaced N+1+IFG_CYCLES cycles apart.
- Field inputs may change freely after edge T without affecting the frame in flight.

## Test plan
- **Reset state:** hold `rst_n`=0, then release → `tx_ready`=1, `tx_data_valid`=0, `tx_data`=8'h00, `tx_done`=0.
- **Basic frame:** accept with dest 48'h0102_0304_0506, src 48'hA1A2_A3A4_A5A6, type 16'h0800, payload 32'hDEADBEEF.
  - Required stream: AA×7, AB, 01 02 03 04 05 06, A1 A2 A3 A4 A5 A6, 08 00, DE AD BE EF, then 4 FCS bytes.
  - The FCS bytes must equal a zlib-CRC32 software model over the 18 covered bytes, sent MSB first.
  - `tx_done` pulses in cycle T+31.
- **Busy and back-to-back:**
  - Pulse `tx_start` at T+5 and again at T+31 → both ignored, and the stream is unchanged.
  - Hold `tx_start`=1 continuously → the second frame's first AA appears at T+44 (IFG_CYCLES=12).
- **Input stability:** change every field input at T+1 → the emitted frame still carries the values latched at T.
- **Reset mid-frame:** assert reset during the 3rd SRC byte → outputs reach reset values immediately and no `tx_done` fires. After release, a new accepted frame is complete and its CRC is correct.
- **Zero fields:** all fields zero with PAYLOAD_BYTES=4 → 18 zero data bytes followed by an FCS equal to the model CRC of 18 bytes of 8'h00. This checks CRC re-initialisation between frames.

Source files
------------

// File: rtl/frame_transmission_if.sv
// Byte-stream transmit bus between a frame source and the Ethernet framer.
// The master supplies the header fields, payload and start request.
// The slave (the framer) returns the ready flag and the outgoing byte stream.
interface frame_transmission_if #(
    parameter int unsigned PAYLOAD_BYTES = 4
);
    logic                       tx_start;
    logic [47:0]                dest_mac;
    logic [47:0]                src_mac;
    logic [15:0]                eth_type;
    logic [8*PAYLOAD_BYTES-1:0] payload;
    logic                       tx_ready;
    logic [7:0]                 tx_data;
    logic                       tx_data_valid;
    logic                       tx_done;

    modport master (
        output tx_start, dest_mac, src_mac, eth_type, payload,
        input  tx_ready, tx_data, tx_data_valid, tx_done
    );

    modport slave (
        input  tx_start, dest_mac, src_mac, eth_type, payload,
        output tx_ready, tx_data, tx_data_valid, tx_done
    );
endinterface

// File: rtl/frame_transmission.sv
// Transmit-side Ethernet framer.
// Latches the header and payload on an accepted start, then emits preamble, SFD, destination,
// source, EtherType, payload and the CRC-32 FCS one byte per clock, followed by an
// inter-frame gap.
module frame_transmission #(
    parameter int unsigned PAYLOAD_BYTES = 4,
    parameter int unsigned IFG_CYCLES    = 12
) (
    input logic                 clk,
    input logic                 rst_n,
    frame_transmission_if.slave bus
);
    localparam int unsigned PAY_W   = 8 * PAYLOAD_BYTES;
    localparam int unsigned MAX_A   = (PAYLOAD_BYTES > 7) ? PAYLOAD_BYTES : 7;
    localparam int unsigned MAX_LEN = (IFG_CYCLES > MAX_A) ? IFG_CYCLES : MAX_A;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'hAA;
    localparam logic [7:0]  SFD_BYTE      = 8'hAB;

    typedef enum logic [3:0] {
        StIdle,
        StPreamble,
        StSfd,
        StDest,
        StSrc,
        StType,
        StPayload,
        StFcs,
        StIfg
    } state_e;

    state_e             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [31:0]        crc_reg;
    logic [47:0]        dest_reg;
    logic [47:0]        src_reg;
    logic [15:0]        type_reg;
    logic [PAY_W-1:0]   payload_reg;

    logic               out_ready;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_done;

    int unsigned        state_len;
    logic               last;
    logic [CNT_W-1:0]   nxt_idx;
    logic [31:0]        fcs;
    logic [7:0]         dest_byte;
    logic [7:0]         src_byte;
    logic [7:0]         type_byte;
    logic [7:0]         pay_byte;
    logic [7:0]         fcs_byte;

    // Reflected CRC-32 update with one byte, LSB bit first.
    function automatic logic [31:0] crc_step(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] r;
        r = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Per-state length, end-of-state detect and the field bytes at the next byte index.
    always_comb begin
        state_len = 1;
        case (state)
            StPreamble: state_len = 7;
            StSfd:      state_len = 1;
            StDest:     state_len = 6;
            StSrc:      state_len = 6;
            StType:     state_len = 2;
            StPayload:  state_len = PAYLOAD_BYTES;
            StFcs:      state_len = 4;
            StIfg:      state_len = IFG_CYCLES;
            default:    state_len = 1;
        endcase
        last    = (byte_cnt == CNT_W'(state_len - 1));
        nxt_idx = last ? '0 : byte_cnt + CNT_W'(1);
        fcs     = ~crc_reg;
        // Fields go out MSB byte first, so index 0 selects the top byte. An index past the end
        // of a field shifts everything out; such bytes are never selected.
        dest_byte = 8'(dest_reg >> (8 * (5 - int'(nxt_idx))));
        src_byte  = 8'(src_reg >> (8 * (5 - int'(nxt_idx))));
        type_byte = 8'(type_reg >> (8 * (1 - int'(nxt_idx))));
        pay_byte  = 8'(payload_reg >> (8 * (int'(PAYLOAD_BYTES) - 1 - int'(nxt_idx))));
        fcs_byte  = 8'(fcs >> (8 * (3 - int'(nxt_idx))));
    end

    // Frame sequencer; every output is registered and holds the byte for the current cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            byte_cnt    <= '0;
            crc_reg     <= CRC_INIT;
            dest_reg    <= '0;
            src_reg     <= '0;
            type_reg    <= '0;
            payload_reg <= '0;
            out_ready   <= 1'b1;
            out_data    <= 8'h00;
            out_valid   <= 1'b0;
            out_done    <= 1'b0;
        end else begin
            out_done <= 1'b0;
            case (state)
                StIdle: begin
                    byte_cnt  <= '0;
                    out_ready <= 1'b1;
                    out_valid <= 1'b0;
                    out_data  <= 8'h00;
                    if (bus.tx_start) begin
                        state       <= StPreamble;
                        dest_reg    <= bus.dest_mac;
                        src_reg     <= bus.src_mac;
                        type_reg    <= bus.eth_type;
                        payload_reg <= bus.payload;
                        crc_reg     <= CRC_INIT;
                        out_ready   <= 1'b0;
                        out_valid   <= 1'b1;
                        out_data    <= PREAMBLE_BYTE;
                    end
                end
                StPreamble: begin
                    byte_cnt <= nxt_idx;
                    if (last) begin
                        state    <= StSfd;
                        out_data <= SFD_BYTE;
                    end else begin
                        out_data <= PREAMBLE_BYTE;
                    end
                end
                StSfd: begin
                    // Single-byte state: nxt_idx is 0, so dest_byte is the first MAC byte.
                    byte_cnt <= nxt_idx;
                    state    <= StDest;
                    out_data <= dest_byte;
                    crc_reg  <= crc_step(crc_reg, dest_byte);
                end
                StDest: begin
                    byte_cnt <= nxt_idx;
                    if (last) begin
                        state    <= StSrc;
                        out_data <= src_byte;
                        crc_reg  <= crc_step(crc_reg, src_byte);
                    end else begin
                        out_data <= dest_byte;
                        crc_reg  <= crc_step(crc_reg, dest_byte);
                    end
                end
                StSrc: begin
                    byte_cnt <= nxt_idx;
                    if (last) begin
                        state    <= StType;
                        out_data <= type_byte;
                        crc_reg  <= crc_step(crc_reg, type_byte);
                    end else begin
                        out_data <= src_byte;
                        crc_reg  <= crc_step(crc_reg, src_byte);
                    end
                end
                StType: begin
                    byte_cnt <= nxt_idx;
                    if (last) begin
                        state    <= StPayload;
                        out_data <= pay_byte;
                        crc_reg  <= crc_step(crc_reg, pay_byte);
                    end else begin
                        out_data <= type_byte;
                        crc_reg  <= crc_step(crc_reg, type_byte);
                    end
                end
                StPayload: begin
                    byte_cnt <= nxt_idx;
                    if (last) begin
                        // crc_reg already covers the final payload byte driven this cycle.
                        state    <= StFcs;
                        out_data <= fcs_byte;
                    end else begin
                        out_data <= pay_byte;
                        crc_reg  <= crc_step(crc_reg, pay_byte);
                    end
                end
                StFcs: begin
                    byte_cnt <= nxt_idx;
                    if (last) begin
                        state     <= StIfg;
                        out_data  <= 8'h00;
                        out_valid <= 1'b0;
                        out_done  <= 1'b1;
                    end else begin
                        out_data <= fcs_byte;
                    end
                end
                StIfg: begin
                    byte_cnt <= nxt_idx;
                    if (last) begin
                        state     <= StIdle;
                        out_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= StIdle;
                    byte_cnt  <= '0;
                    out_ready <= 1'b1;
                    out_data  <= 8'h00;
                    out_valid <= 1'b0;
                    out_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_ready      = out_ready;
    assign bus.tx_data       = out_data;
    assign bus.tx_data_valid = out_valid;
    assign bus.tx_done       = out_done;

endmodule

// File: tb/tb_frame_transmission.sv
// Self-checking bench for frame_transmission: directed scenarios with randomized fields,
// compared against a byte-list frame model with a table-driven CRC-32.
module tb_frame_transmission;
    localparam int unsigned P   = 4;
    localparam int unsigned IFG = 12;
    localparam int unsigned N   = 26 + P;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    frame_transmission_if #(.PAYLOAD_BYTES(P)) bus ();

    frame_transmission #(
        .PAYLOAD_BYTES(P),
        .IFG_CYCLES   (IFG)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] crc_table [256];
    logic [7:0]  exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag, input logic ready);
        check({tag, " valid"}, {63'h0, bus.tx_data_valid}, 64'h0);
        check({tag, " data"}, {56'h0, bus.tx_data}, 64'h0);
        check({tag, " done"}, {63'h0, bus.tx_done}, 64'h0);
        check({tag, " ready"}, {63'h0, bus.tx_ready}, {63'h0, ready});
    endtask

    task automatic scramble();
        bus.dest_mac = {16'($urandom()), $urandom()};
        bus.src_mac  = {16'($urandom()), $urandom()};
        bus.eth_type = 16'($urandom());
        for (int k = 0; k < P; k++) bus.payload[8*k +: 8] = 8'($urandom());
    endtask

    // Reference frame: fixed preamble/SFD, fields MSB byte first, zlib CRC-32 sent MSB first.
    task automatic build_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                               input logic [8*P-1:0] p);
        logic [7:0]  body [$];
        logic [31:0] c;
        exp_q.delete();
        for (int k = 5; k >= 0; k--) body.push_back(d[8*k +: 8]);
        for (int k = 5; k >= 0; k--) body.push_back(s[8*k +: 8]);
        for (int k = 1; k >= 0; k--) body.push_back(t[8*k +: 8]);
        for (int k = P - 1; k >= 0; k--) body.push_back(p[8*k +: 8]);
        c = 32'hFFFF_FFFF;
        foreach (body[k]) c = crc_table[c[7:0] ^ body[k]] ^ (c >> 8);
        c = ~c;
        repeat (7) exp_q.push_back(8'hAA);
        exp_q.push_back(8'hAB);
        foreach (body[k]) exp_q.push_back(body[k]);
        for (int k = 3; k >= 0; k--) exp_q.push_back(c[8*k +: 8]);
    endtask

    // Accepts a frame from the current field inputs and checks every cycle up to ready again.
    // pulse_a/pulse_b: cycles (relative to accept) carrying a stray start; hold keeps start high;
    // abort_at: byte index at which reset is asserted (-1 for none).
    task automatic send_frame(input string tag, input int pulse_a, input int pulse_b,
                              input bit hold, input int abort_at);
        build_frame(bus.dest_mac, bus.src_mac, bus.eth_type, bus.payload);
        check({tag, " ready_pre"}, {63'h0, bus.tx_ready}, 64'h1);
        bus.tx_start = 1'b1;
        tick();
        scramble();
        for (int i = 0; i < int'(N); i++) begin
            bus.tx_start = hold || (i + 1 == pulse_a) || (i + 1 == pulse_b);
            check($sformatf("%s byte%0d data", tag, i), {56'h0, bus.tx_data}, {56'h0, exp_q[i]});
            check($sformatf("%s byte%0d valid", tag, i), {63'h0, bus.tx_data_valid}, 64'h1);
            check($sformatf("%s byte%0d done", tag, i), {63'h0, bus.tx_done}, 64'h0);
            check($sformatf("%s byte%0d ready", tag, i), {63'h0, bus.tx_ready}, 64'h0);
            if (i == abort_at) begin
                bus.tx_start = 1'b0;
                rst_n = 1'b0;
                #1;
                check_quiet({tag, " in_reset"}, 1'b1);
                repeat (3) tick();
                rst_n = 1'b1;
                for (int k = 0; k < int'(N); k++) begin
                    tick();
                    check_quiet($sformatf("%s after_abort%0d", tag, k), 1'b1);
                end
                return;
            end
            tick();
        end
        bus.tx_start = hold || (int'(N) + 1 == pulse_a) || (int'(N) + 1 == pulse_b);
        check({tag, " done_pulse"}, {63'h0, bus.tx_done}, 64'h1);
        check({tag, " ifg0 valid"}, {63'h0, bus.tx_data_valid}, 64'h0);
        check({tag, " ifg0 data"}, {56'h0, bus.tx_data}, 64'h0);
        check({tag, " ifg0 ready"}, {63'h0, bus.tx_ready}, 64'h0);
        for (int k = 2; k <= int'(IFG); k++) begin
            tick();
            bus.tx_start = hold || (int'(N) + k == pulse_a) || (int'(N) + k == pulse_b);
            check_quiet($sformatf("%s ifg%0d", tag, k - 1), 1'b0);
        end
        tick();
        bus.tx_start = hold;
        check_quiet({tag, " ready_back"}, 1'b1);
    endtask

    initial begin
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_table[n] = c;
        end

        bus.tx_start = 1'b0;
        bus.dest_mac = '0;
        bus.src_mac  = '0;
        bus.eth_type = '0;
        bus.payload  = '0;

        // Reset state, during and after reset.
        repeat (3) tick();
        check_quiet("reset_held", 1'b1);
        rst_n = 1'b1;
        tick();
        check_quiet("reset_released", 1'b1);
        tick();

        // Basic frame with the reference field values.
        bus.dest_mac = 48'h0102_0304_0506;
        bus.src_mac  = 48'hA1A2_A3A4_A5A6;
        bus.eth_type = 16'h0800;
        bus.payload  = 32'hDEAD_BEEF;
        send_frame("basic", -1, -1, 1'b0, -1);
        tick();
        check_quiet("basic idle", 1'b1);

        // Stray starts while busy, including the tx_done cycle.
        scramble();
        send_frame("busy", 5, 31, 1'b0, -1);
        tick();
        check_quiet("busy idle", 1'b1);

        // Start held high: second frame follows with minimum spacing.
        scramble();
        send_frame("b2b_a", -1, -1, 1'b1, -1);
        send_frame("b2b_b", -1, -1, 1'b0, -1);
        tick();

        // Reset during the 3rd source MAC byte, then a clean frame.
        scramble();
        send_frame("abort", -1, -1, 1'b0, 16);
        scramble();
        send_frame("post_abort", -1, -1, 1'b0, -1);
        tick();

        // All-zero fields.
        bus.dest_mac = '0;
        bus.src_mac  = '0;
        bus.eth_type = '0;
        bus.payload  = '0;
        send_frame("zero", -1, -1, 1'b0, -1);

        // Random frames with a random idle gap before each.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 3)) tick();
            scramble();
            send_frame($sformatf("rand%0d", r), -1, -1, 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
